// File: rtl/node_mac_sequencer.sv
// node_mac_sequencer: time-multiplexed fp32 neuron. One shared multiplier
// and one shared adder accumulate N_INPUTS activation*weight products, then
// the result is presented on a valid/ready output.
// Optional feature macro: NODE_RELU_EN (clamp negative results to +0.0).
//
// Handshakes: a beat/result transfers on a rising edge where valid & ready
// are both high. in_ready depends only on state (and is low during rst).
// out_valid never depends on out_ready. out_data is held stable while
// out_valid & ~out_ready.

// float_mult: fp32 multiply. Zero/denormal inputs give signed zero,
// mantissa truncated, exponent overflow saturates to infinity, underflow
// flushes to zero.
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [47:0]       p;
  logic [22:0]       mant;
  logic signed [9:0] e;
  logic              sgn;

  // Multiply mantissas, normalise by at most one place, range-check exponent.
  always_comb begin
    sgn  = a[31] ^ b[31];
    p    = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    mant = p[47] ? p[46:24] : p[45:23];
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
           - 10'sd127 + $signed({9'd0, p[47]});
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0)
      y = {sgn, 31'd0};
    else if (e >= 10'sd255)
      y = {sgn, 8'hff, 23'd0};
    else
      y = {sgn, e[7:0], mant};
  end
endmodule

// float_adder: fp32 add with two guard bits and truncation. Exact
// cancellation yields +0.0; zero/denormal operands count as zero.
module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]       big, sml;
  logic [25:0]       mbig, msml, msh;
  logic [26:0]       s, sn;
  logic [7:0]        d;
  logic [4:0]        p, shift;
  logic signed [9:0] e;
  logic [22:0]       mant;

  // Align the smaller magnitude to the larger, add/subtract, renormalise.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mbig  = (big[30:23] == 8'd0) ? 26'd0 : {1'b1, big[22:0], 2'b00};
    msml  = (sml[30:23] == 8'd0) ? 26'd0 : {1'b1, sml[22:0], 2'b00};
    d     = big[30:23] - sml[30:23];
    msh   = (d > 8'd25) ? 26'd0 : (msml >> d);
    if (big[31] == sml[31]) s = {1'b0, mbig} + {1'b0, msh};
    else                    s = {1'b0, mbig} - {1'b0, msh};
    e     = $signed({2'b00, big[30:23]});
    p     = 5'd0;
    for (int i = 0; i < 26; i++)
      if (s[i]) p = 5'(i);
    shift = 5'd25 - p;
    sn    = s << shift;
    mant  = sn[24:2];
    if (s[26]) begin
      mant = s[25:3];
      e    = e + 10'sd1;
    end else begin
      e    = e - $signed({5'd0, shift});
    end
    if (s == 27'd0 || e <= 10'sd0)
      y = 32'h0;
    else if (e >= 10'sd255)
      y = {big[31], 8'hff, 23'd0};
    else
      y = {big[31], e[7:0], mant};
  end
endmodule

module node_mac_sequencer #(
  parameter int N_INPUTS = 15,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [IDX_W-1:0] w_addr,
  input  logic [31:0]      w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             err
);
  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      acc_q, acc_d, out_data_d;
  logic             out_valid_d, err_d;
  logic [31:0]      prod, sum;
  logic             beat, last_cnt;

  float_mult  u_mult (.a(in_data), .b(w_data), .y(prod));
  float_adder u_add  (.a(acc_q),   .b(prod),   .y(sum));

  assign w_addr   = idx_q;
  assign in_ready = (state_q == ACCUM) && !rst;
  assign beat     = in_valid && in_ready;
  assign last_cnt = (idx_q == IDX_W'(N_INPUTS - 1));

  function automatic logic [31:0] shape(input logic [31:0] v);
`ifdef NODE_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Next-state and datapath: MAC per accepted beat, frame end loads result.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    err_d       = err;
    case (state_q)
      ACCUM: begin
        if (beat) begin
          // First beat loads the product directly; no add against stale acc.
          acc_d = (idx_q == '0) ? prod : sum;
          idx_d = idx_q + IDX_W'(1);
          if (last_cnt || in_last) begin
            idx_d       = '0;
            state_d     = OUTPUT;
            out_valid_d = 1'b1;
            out_data_d  = shape(acc_d);
            // Marker and count disagree: truncated or unterminated frame.
            if (in_last ^ last_cnt) err_d = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      acc_q     <= 32'h0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      err       <= err_d;
    end
  end
endmodule
